// File: rtl/bus_preload_responder.sv
// Preloads a value onto a shared bus after a turnaround, with optional
// readback check (`define RESP_READBACK_EN adds the CHECK state).
//
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   start_i, data_i      - request a preload of data_i (taken in IDLE only)
//   busy_o, done_o       - FSM activity, one-cycle completion pulse
//   load_o               - one-cycle load request to the counter peer
//   bus_i/bus_o/bus_oe_o - shared bus input, output value, per-bit enable
//   obs_o                - last bus value seen while not driving
//   match_o, mismatch_o  - readback result (constant 0 without the macro)
//   xfer_cnt_o           - completed-transaction count, wraps at 8 bits
module bus_preload_responder #(
  parameter int DATA_W      = 8,
  parameter int TURN_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              load_o,
  input  logic [DATA_W-1:0] bus_i,
  output logic [DATA_W-1:0] bus_o,
  output logic [DATA_W-1:0] bus_oe_o,
  output logic [DATA_W-1:0] obs_o,
  output logic              match_o,
  output logic              mismatch_o,
  output logic [7:0]        xfer_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_TURN    = 3'd2,
    S_DRIVE   = 3'd3,
    S_RECOVER = 3'd4
`ifdef RESP_READBACK_EN
    ,
    S_CHECK   = 3'd5
`endif
  } state_t;

  // Counter is loaded with N-1 so TURN lasts exactly N cycles
  localparam logic [3:0] TURN_LOAD = 4'(TURN_CYCLES - 1);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] obs_q, obs_d;
  logic [3:0]        turn_q, turn_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              load_q, load_d;
  logic              oe_q, oe_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
`ifdef RESP_READBACK_EN
  logic              match_q, match_d;
  logic              mism_q, mism_d;
`endif

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    turn_d  = turn_q;
    cnt_d   = cnt_q;
    load_d  = 1'b0;
    oe_d    = 1'b0;
    done_d  = 1'b0;
    busy_d  = 1'b1;
    // Bus observed only while we are not the one driving it
    obs_d   = oe_q ? obs_q : bus_i;
`ifdef RESP_READBACK_EN
    match_d = match_q;
    mism_d  = mism_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (start_i) begin
          state_d = S_REQ;
          data_d  = data_i;
          load_d  = 1'b1;
          busy_d  = 1'b1;
        end
      end
      S_REQ: begin
        state_d = S_TURN;
        turn_d  = TURN_LOAD;
      end
      S_TURN: begin
        if (turn_q == 4'd0) begin
          state_d = S_DRIVE;
          oe_d    = 1'b1;
        end else begin
          turn_d = turn_q - 4'd1;
        end
      end
      S_DRIVE: begin
        state_d = S_RECOVER;
      end
      S_RECOVER: begin
`ifdef RESP_READBACK_EN
        state_d = S_CHECK;
`else
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        cnt_d   = cnt_q + 8'd1;
`endif
      end
`ifdef RESP_READBACK_EN
      S_CHECK: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        cnt_d   = cnt_q + 8'd1;
        match_d = (bus_i == data_q);
        mism_d  = (bus_i != data_q);
      end
`endif
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      obs_q   <= '0;
      turn_q  <= 4'd0;
      cnt_q   <= 8'd0;
      load_q  <= 1'b0;
      oe_q    <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef RESP_READBACK_EN
      match_q <= 1'b0;
      mism_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      obs_q   <= obs_d;
      turn_q  <= turn_d;
      cnt_q   <= cnt_d;
      load_q  <= load_d;
      oe_q    <= oe_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
`ifdef RESP_READBACK_EN
      match_q <= match_d;
      mism_q  <= mism_d;
`endif
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign load_o     = load_q;
  assign bus_o      = data_q;
  assign bus_oe_o   = {DATA_W{oe_q}};
  assign obs_o      = obs_q;
  assign xfer_cnt_o = cnt_q;
`ifdef RESP_READBACK_EN
  assign match_o    = match_q;
  assign mismatch_o = mism_q;
`else
  assign match_o    = 1'b0;
  assign mismatch_o = 1'b0;
`endif

endmodule

// File: tb/tb_bus_preload_responder.sv
// Bench for bus_preload_responder: offset-based transaction model,
// directed scenarios, randomized traffic and a TURN_CYCLES=4 instance.
module tb_bus_preload_responder;
  localparam int W = 8;
  localparam int T = 2;
`ifdef RESP_READBACK_EN
  localparam int RB = 1;
`else
  localparam int RB = 0;
`endif
  localparam int LEN = T + 3 + RB;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] din = '0;
  logic [W-1:0] peer = '0;
  logic [W-1:0] bus_w;
  logic [W-1:0] bus_o, oe, obs;
  logic         busy, done, load, match, mism;
  logic [7:0]   cnt;

  // Shared bus as the responder sees it: its own drive, else the peer
  assign bus_w = oe[0] ? bus_o : peer;

  bus_preload_responder #(.DATA_W(W), .TURN_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .start_i(start), .data_i(din),
    .busy_o(busy), .done_o(done), .load_o(load),
    .bus_i(bus_w), .bus_o(bus_o), .bus_oe_o(oe), .obs_o(obs),
    .match_o(match), .mismatch_o(mism), .xfer_cnt_o(cnt)
  );

  logic         r2 = 1'b1;
  logic         s2 = 1'b0;
  logic [W-1:0] d2 = '0;
  logic [W-1:0] b2 = 8'h3C;
  logic [W-1:0] bo2, oe2, obs2;
  logic         busy2, done2, load2, match2, mism2;
  logic [7:0]   cnt2;

  bus_preload_responder #(.DATA_W(W), .TURN_CYCLES(4)) dut2 (
    .clk(clk), .rst(r2), .start_i(s2), .data_i(d2),
    .busy_o(busy2), .done_o(done2), .load_o(load2),
    .bus_i(b2), .bus_o(bo2), .bus_oe_o(oe2), .obs_o(obs2),
    .match_o(match2), .mismatch_o(mism2), .xfer_cnt_o(cnt2)
  );

  int checks = 0;
  int failures = 0;

  // Model: off = cycles since the accepting edge, -1 when idle
  int           off = -1;
  logic [W-1:0] m_data = '0;
  logic [W-1:0] m_obs = '0;
  logic [7:0]   m_cnt = 8'd0;
  bit           m_done = 1'b0;
  bit           m_match = 1'b0;
  bit           m_mism = 1'b0;
  int           m_ndone = 0;
  logic [W-1:0] cap = '0;

  task automatic chk(input string tag,
                     input logic [15:0] o,
                     input logic [15:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic model(input bit r, input bit s,
                       input logic [W-1:0] d,
                       input logic [W-1:0] sb);
    bit poe;
    poe = (off == T + 1);
    if (r) begin
      off = -1; m_data = '0; m_obs = '0; m_cnt = 8'd0;
      m_done = 0; m_match = 0; m_mism = 0;
    end else begin
      m_done = 0;
      if (!poe) m_obs = sb;
      if (off < 0) begin
        if (s) begin
          off = 0;
          m_data = d;
        end
      end else begin
        off++;
        if (off == LEN) begin
          off = -1;
          m_done = 1;
          m_ndone++;
          m_cnt = m_cnt + 8'd1;
          if (RB == 1) begin
            m_match = (sb == m_data);
            m_mism = (sb != m_data);
          end
        end
      end
    end
  endtask

  task automatic step(input bit r, input bit s,
                      input logic [W-1:0] d,
                      input logic [W-1:0] p);
    logic [W-1:0] sb;
    @(negedge clk);
    rst = r; start = s; din = d; peer = p;
    #1;
    sb = bus_w;
    @(posedge clk);
    #1;
    model(r, s, d, sb);
    if (oe[0]) cap = bus_o;
    chk("load", 16'(load), 16'(off == 0));
    chk("bus_oe", 16'(oe),
        (off == T + 1) ? 16'(8'hFF) : 16'd0);
    chk("busy", 16'(busy), 16'(off >= 0));
    chk("done", 16'(done), 16'(m_done));
    chk("bus_o", 16'(bus_o), 16'(m_data));
    chk("obs", 16'(obs), 16'(m_obs));
    chk("xfer_cnt", 16'(cnt), 16'(m_cnt));
    chk("match", 16'(match), 16'(m_match));
    chk("mismatch", 16'(mism), 16'(m_mism));
  endtask

  initial begin
    int n0;
    int first_load;
    int oe_at;
    int busy_n;
    int load_n;
    logic [W-1:0] oe_val;

    // Reset
    step(1, 0, 8'h00, 8'h00);
    step(1, 1, 8'hAA, 8'h00);
    chk("rst_cnt", 16'(cnt), 16'd0);
    chk("rst_bus_o", 16'(bus_o), 16'd0);

    // Single transfer 0x5A, peer echoes captured value
    step(0, 1, 8'h5A, 8'h00);
    chk("first_load", 16'(load), 16'd1);
    for (int i = 0; i < LEN + 1; i++)
      step(0, 0, 8'h00, cap);
    chk("first_cnt", 16'(cnt), 16'd1);
    chk("echo_match", 16'(match), 16'(RB));
    chk("echo_mism", 16'(mism), 16'd0);

    // Peer echoes a wrong value
    step(0, 1, 8'h5A, 8'h00);
    for (int i = 0; i < LEN + 1; i++)
      step(0, 0, 8'h00, cap + 8'd1);
    chk("bad_mism", 16'(mism), 16'(RB));
    chk("bad_match", 16'(match), 16'd0);

    // Start during TURN is ignored
    n0 = m_ndone;
    step(0, 1, 8'h5A, 8'h21);
    step(0, 0, 8'h00, 8'h22);
    step(0, 1, 8'h11, 8'h23);
    for (int i = 0; i < LEN + 1; i++)
      step(0, 0, 8'h00, 8'h24);
    chk("ign_data", 16'(bus_o), 16'h5A);
    chk("ign_dones", 16'(m_ndone - n0), 16'd1);

    // Reset while driving
    step(0, 1, 8'h77, 8'h30);
    for (int i = 0; i < 20 && off != T + 1; i++)
      step(0, 0, 8'h00, 8'h31);
    chk("in_drive", 16'(oe), 16'(8'hFF));
    step(1, 0, 8'h00, 8'h32);
    chk("rstd_oe", 16'(oe), 16'd0);
    chk("rstd_load", 16'(load), 16'd0);
    chk("rstd_done", 16'(done), 16'd0);
    step(0, 0, 8'h00, 8'h33);

    // 256 back-to-back transfers wrap the counter
    step(1, 0, 8'h00, 8'h00);
    n0 = m_ndone;
    for (int i = 0; i < 256 * (LEN + 1) + 20; i++) begin
      if (m_ndone - n0 >= 256) break;
      step(0, 1, 8'($urandom), 8'($urandom));
    end
    chk("wrap_n", 16'(m_ndone - n0), 16'd256);
    chk("wrap_cnt", 16'(cnt), 16'd0);

    // Randomized traffic
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 49) == 0,
           $urandom_range(0, 2) == 0,
           8'($urandom), 8'($urandom));

    // TURN_CYCLES=4 instance timing
    @(negedge clk);
    r2 = 1'b0;
    s2 = 1'b1;
    d2 = 8'hC3;
    first_load = -1; oe_at = -1;
    busy_n = 0; load_n = 0; oe_val = '0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (load2) begin
        load_n++;
        if (first_load < 0) first_load = i;
      end
      if (oe2 == 8'hFF && oe_at < 0) begin
        oe_at = i;
        oe_val = bo2;
      end
      if (busy2) busy_n++;
      @(negedge clk);
      s2 = 1'b0;
    end
    chk("t4_load_n", 16'(load_n), 16'd1);
    chk("t4_oe_delay", 16'(oe_at - first_load), 16'd5);
    chk("t4_bus", 16'(oe_val), 16'hC3);
    chk("t4_busy", 16'(busy_n), 16'(7 + RB));
    chk("t4_cnt", 16'(cnt2), 16'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_preload_responder.md
BUS_PRELOAD_RESPONDER -- requirements
Module: bus_preload_responder

Interface
REQ-001 Parameter DATA_W, default 8: bus and data width; SHALL support 4..16.
REQ-002 Parameter TURN_CYCLES, default 2: cycles between load request and drive window (partner release latency); SHALL support 1..15.
REQ-003 clk  input  1  single clock; all state SHALL change on rising edge only.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start_i  input  1  request one preload transaction; sampled only in IDLE.
REQ-006 data_i  input  DATA_W  preload value; latched into data_q on accepted start.
REQ-007 busy_o  output  1  high whenever FSM not in IDLE.
REQ-008 done_o  output  1  one-cycle pulse on transaction completion.
REQ-009 load_o  output  1  load request line to the counter peer.
REQ-010 bus_i  input  DATA_W  shared bidirectional bus, input path.
REQ-011 bus_o  output  DATA_W  shared bus, output path; SHALL equal data_q.
REQ-012 bus_oe_o  output  DATA_W  per-bit drive enable, all bits equal; 1 = drive.
REQ-013 obs_o  output  DATA_W  last bus value sampled while not driving.
REQ-014 match_o / mismatch_o  output  1 each  readback result flags (see Configuration).
REQ-015 xfer_cnt_o  output  8  completed-transaction count.

Function
REQ-016 FSM states SHALL be IDLE, REQ, TURN, DRIVE, RECOVER, CHECK; all outputs registered.
REQ-017 IDLE: start_i=1 SHALL latch data_i, move to REQ next edge; start_i outside IDLE SHALL be ignored (no queueing).
REQ-018 REQ: exactly 1 cycle, load_o=1; load_o SHALL be 0 in every other state.
REQ-019 TURN: exactly TURN_CYCLES cycles, bus_oe_o=0, tracked by a 4-bit down-counter.
REQ-020 DRIVE: exactly 1 cycle, bus_oe_o=all ones, bus_o=data_q; bus_oe_o SHALL be 0 in every other state.
REQ-021 RECOVER: exactly 1 cycle, bus_oe_o=0; then CHECK if readback compiled in, else IDLE.
REQ-022 CHECK: 1 cycle; sample bus_i, set match_o=(bus_i==data_q), mismatch_o=inverse; go to IDLE.
REQ-023 done_o SHALL pulse in the cycle the FSM returns to IDLE; xfer_cnt_o SHALL increment in the same cycle, wrapping 0xFF->0x00.
REQ-024 With default TURN_CYCLES, load_o rises at edge E0 and bus_oe_o is high between E3 and E4; total busy = 5 cycles (6 with CHECK).
REQ-025 obs_o SHALL register bus_i every cycle where bus_oe_o=0 and hold otherwise.
REQ-026 match_o/mismatch_o SHALL hold until the next CHECK or reset; never both high.
REQ-027 start_i held high continuously SHALL produce back-to-back transactions with one IDLE cycle between them.

Reset
REQ-028 rst=1 at an edge SHALL force IDLE, load_o=0, bus_oe_o=0, done_o=0, busy_o=0, match_o=0, mismatch_o=0, obs_o=0, xfer_cnt_o=0, data_q=0.
REQ-029 rst asserted mid-transaction (including DRIVE) SHALL release the bus at that edge, with no done_o pulse and no xfer_cnt_o increment.
REQ-030 rst SHALL take priority over start_i.

Configuration
REQ-031 Macro RESP_READBACK_EN defined: CHECK state and match/mismatch logic SHALL be present as in REQ-022/026.
REQ-032 RESP_READBACK_EN undefined: CHECK SHALL be absent, RECOVER goes to IDLE, and match_o/mismatch_o SHALL be constant 0.

Verification
REQ-033 Reset, then start_i=1 for 1 cycle with data_i=0x5A -> load_o high 1 cycle; bus_oe_o=0xFF for exactly 1 cycle, 3 cycles after load_o rise; bus_o=0x5A; done_o pulse; xfer_cnt_o=1.
REQ-034 Counter-peer model captures the DRIVE value and echoes 0x5A -> match_o=1, mismatch_o=0 (readback build); peer echoes 0x5B -> mismatch_o=1.
REQ-035 start_i pulsed during TURN with data_i=0x11 -> ignored; data_q stays 0x5A; only one done_o.
REQ-036 rst asserted during DRIVE -> bus_oe_o=0 and load_o=0 after that edge; xfer_cnt_o unchanged; no done_o.
REQ-037 256 back-to-back transactions -> xfer_cnt_o wraps to 0x00; peer drives bus in idle cycles, obs_o tracks bus_i and never updates during DRIVE.
REQ-038 TURN_CYCLES=4, data_i=0xC3 -> bus_oe_o asserted 5 cycles after load_o rise; busy_o high 8 cycles (readback build).
